// File: rtl/fixed_product_vector_accumulator.sv
// fixed_product_vector_accumulator
// Accumulates IN_DEPTH beats of IN_SIZE signed product elements into one dot
// product. The result sits in a single output register with a valid/ready
// handshake.
// Optional feature: define FIXED_PRODUCT_ACC_SATURATE_EN to saturate, rather
// than wrap, when narrowing from ACC_WIDTH to OUT_WIDTH.
module fixed_product_vector_accumulator #(
    parameter int IN_SIZE   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int IN_DEPTH  = 4,
    parameter int ACC_WIDTH = IN_WIDTH + $clog2(IN_SIZE) + $clog2(IN_DEPTH),
    parameter int OUT_WIDTH = ACC_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]   data_in,
    input  logic                               data_in_valid,
    output logic                               data_in_ready,
    output logic signed [OUT_WIDTH-1:0]        data_out,
    output logic                               data_out_valid,
    input  logic                               data_out_ready
);

    // A 1-bit counter is kept even for IN_DEPTH==1; it then never leaves 0.
    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

    logic [CNT_W-1:0]                  cnt_reg, cnt_next;
    logic [ACC_WIDTH-1:0]              acc_reg, acc_next;
    logic [OUT_WIDTH-1:0]              data_out_reg, data_out_next;
    logic                              out_valid_reg, out_valid_next;

    logic [IN_SIZE-1:0][ACC_WIDTH-1:0] elem_ext;
    logic [ACC_WIDTH-1:0]              beat_sum;
    logic [ACC_WIDTH-1:0]              acc_total;
    logic [OUT_WIDTH-1:0]              narrowed;
    logic                              beat_accept;
    logic                              final_beat;

    // Every element is sign-extended to full precision before reduction.
    genvar gi;
    generate
        for (gi = 0; gi < IN_SIZE; gi++) begin : g_ext
            assign elem_ext[gi] = ACC_WIDTH'($signed(data_in[gi]));
        end
    endgenerate

    // Combinational reduction of one beat; ACC_WIDTH leaves room for the sum.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            beat_sum = beat_sum + elem_ext[i];
        end
    end

    assign acc_total = acc_reg + beat_sum;

    // Narrowing of the completed dot product to the output width.
    generate
        if (OUT_WIDTH == ACC_WIDTH) begin : g_full
            assign narrowed = acc_total;
        end else begin : g_narrow
`ifdef FIXED_PRODUCT_ACC_SATURATE_EN
            // Bits above the output sign bit must all match the sign,
            // otherwise the value is out of range and gets clamped.
            logic [ACC_WIDTH-OUT_WIDTH:0] top_bits;
            logic [OUT_WIDTH-1:0]         sat_min;
            assign top_bits = acc_total[ACC_WIDTH-1:OUT_WIDTH-1];
            // Clamp to the most negative / most positive output value.
            always_comb begin
                sat_min                = '0;
                sat_min[OUT_WIDTH-1]   = 1'b1;
                if ((&top_bits) || !(|top_bits)) begin
                    narrowed = OUT_WIDTH'(acc_total);
                end else if (acc_total[ACC_WIDTH-1]) begin
                    narrowed = sat_min;
                end else begin
                    narrowed = ~sat_min;
                end
            end
`else
            assign narrowed = OUT_WIDTH'(acc_total);
`endif
        end
    endgenerate

    // Input is stalled only while a result waits and is not being drained.
    assign data_in_ready = !out_valid_reg || data_out_ready;
    assign beat_accept   = data_in_valid && data_in_ready;
    assign final_beat    = beat_accept && (cnt_reg == LAST_CNT);

    // Next-state logic: accumulate, complete a dot product, drain the output.
    always_comb begin
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        data_out_next  = data_out_reg;
        out_valid_next = out_valid_reg;
        if (out_valid_reg && data_out_ready) begin
            out_valid_next = 1'b0;
        end
        if (final_beat) begin
            // A final beat wins over a same-cycle drain: new result loads.
            cnt_next       = '0;
            acc_next       = '0;
            data_out_next  = narrowed;
            out_valid_next = 1'b1;
        end else if (beat_accept) begin
            cnt_next = cnt_reg + CNT_W'(1);
            acc_next = acc_total;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            acc_reg       <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign data_out       = data_out_reg;
    assign data_out_valid = out_valid_reg;

endmodule

// File: tb/tb_fixed_product_vector_accumulator.sv
// Bench for fixed_product_vector_accumulator: a full-width instance and an
// OUT_WIDTH=8 instance share the same stimulus; a beat-level model predicts
// handshake, validity and the dot product of each vector.
module tb_fixed_product_vector_accumulator;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int AW = 11;
    localparam int NW = 8;

    logic               clk;
    logic               rst;
    logic [N-1:0][W-1:0] data_in;
    logic               data_in_valid;
    logic               data_out_ready;
    logic               ready_w, ready_n;
    logic               vout_w, vout_n;
    logic [AW-1:0]      dout_w;
    logic [NW-1:0]      dout_n;

    int total = 0;
    int bad   = 0;

    // Model state: beat sums of the vector in progress and the pending result.
    int partial[$];
    bit exp_valid;
    int exp_tot;

    fixed_product_vector_accumulator #(
        .IN_SIZE(N), .IN_WIDTH(W), .IN_DEPTH(D)
    ) dut_w (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(ready_w), .data_out(dout_w), .data_out_valid(vout_w),
        .data_out_ready(data_out_ready)
    );

    fixed_product_vector_accumulator #(
        .IN_SIZE(N), .IN_WIDTH(W), .IN_DEPTH(D), .OUT_WIDTH(NW)
    ) dut_n (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(ready_n), .data_out(dout_n), .data_out_valid(vout_n),
        .data_out_ready(data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0][W-1:0] mk(input int a, input int b, input int c, input int d);
        logic [N-1:0][W-1:0] v;
        v[0] = 8'(a);
        v[1] = 8'(b);
        v[2] = 8'(c);
        v[3] = 8'(d);
        return v;
    endfunction

    // Expected 8-bit result from the exact integer dot product.
    function automatic int narrow8(input int t);
`ifdef FIXED_PRODUCT_ACC_SATURATE_EN
        if (t > 127)  return 127 & 32'hFF;
        if (t < -128) return 32'h80;
        return t & 32'hFF;
`else
        return ((t % 256) + 256) % 256;
`endif
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the
    // observable state, advance the model, then step to the next falling edge.
    task automatic cycle(input bit vld, input logic [N-1:0][W-1:0] b, input bit ordy);
        int  bsum;
        bit  accept;
        data_in        = b;
        data_in_valid  = vld;
        data_out_ready = ordy;
        #1;
        chk("ready_w", ready_w, !exp_valid || ordy);
        chk("ready_n", ready_n, !exp_valid || ordy);
        chk("valid_w", vout_w, exp_valid);
        chk("valid_n", vout_n, exp_valid);
        if (exp_valid) begin
            chk("data_w", dout_w, exp_tot & 32'h7FF);
            chk("data_n", dout_n, narrow8(exp_tot));
        end
        accept = vld && (!exp_valid || ordy);
        if (exp_valid && ordy) exp_valid = 1'b0;
        if (accept) begin
            bsum = 0;
            for (int i = 0; i < N; i++) bsum += int'($signed(b[i]));
            partial.push_back(bsum);
            if (partial.size() == D) begin
                exp_tot = 0;
                foreach (partial[k]) exp_tot += partial[k];
                partial.delete();
                exp_valid = 1'b1;
            end
        end
        $display("cyc vld=%0b ordy=%0b acc=%0b exp_valid=%0b exp=%0d dout_w=%0d dout_n=%0d",
                 vld, ordy, accept, exp_valid, exp_tot, $signed(dout_w), $signed(dout_n));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges, outputs checked at once.
    task automatic rst_pulse();
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_valid_w", vout_w, 0);
        chk("rst_valid_n", vout_n, 0);
        chk("rst_data_w", dout_w, 0);
        chk("rst_data_n", dout_n, 0);
        chk("rst_ready_w", ready_w, 1);
        $display("reset pulse applied");
        #1 rst = 1'b1;
        partial.delete();
        exp_valid = 1'b0;
        exp_tot   = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0][W-1:0] zero_beat;
        zero_beat      = '0;
        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        exp_valid      = 1'b0;
        exp_tot        = 0;
        #12;
        chk("reset_valid", vout_w, 0);
        chk("reset_data", dout_w, 0);
        chk("reset_ready", ready_w, 1);
        chk("reset_ready_n", ready_n, 1);
        @(negedge clk);
        rst = 1'b1;

        // Simple dot product, result one cycle after the final beat.
        cycle(1, mk(1, 2, 3, 4), 1);
        cycle(1, mk(5, 6, 7, 8), 1);
        chk("dot36_valid", vout_w, 1);
        chk("dot36", dout_w, 36);
        cycle(0, zero_beat, 1);

        // Negative result.
        cycle(1, mk(-1, -1, -1, -1), 1);
        cycle(1, mk(-1, -1, -1, -1), 1);
        chk("neg8", dout_w, 32'h7F8);
        chk("neg8_n", dout_n, 32'hF8);
        cycle(0, zero_beat, 1);

        // Backpressure: result pending three cycles while next vector waits.
        cycle(1, mk(1, 1, 1, 1), 1);
        cycle(1, mk(2, 2, 2, 2), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, mk(3, 3, 3, 3), 0);
            chk("stall_ready", ready_w, 0);
            chk("stall_hold", dout_w, 12);
        end
        cycle(1, mk(3, 3, 3, 3), 1);
        cycle(1, mk(4, 4, 4, 4), 1);
        chk("after_drain", dout_w, 28);
        cycle(0, zero_beat, 1);

        // Back-to-back vectors at full throughput.
        for (int v = 0; v < 4; v++) begin
            cycle(1, mk(v, v + 1, -v, 2), 1);
            cycle(1, mk(3, v, v, -1), 1);
        end
        cycle(0, zero_beat, 1);

        // Reset while a result is pending.
        cycle(1, mk(5, 5, 5, 5), 1);
        cycle(1, mk(5, 5, 5, 5), 0);
        rst_pulse();
        // Reset discards a partial accumulation.
        cycle(1, mk(9, 9, 9, 9), 1);
        rst_pulse();
        cycle(1, mk(1, 1, 1, 1), 1);
        cycle(1, mk(1, 1, 1, 1), 1);
        chk("post_reset_dot", dout_w, 8);
        cycle(0, zero_beat, 1);

        // Narrowing: 1016 does not fit 8 bits.
        cycle(1, mk(127, 127, 127, 127), 1);
        cycle(1, mk(127, 127, 127, 127), 1);
        chk("wide_1016", dout_w, 1016);
`ifdef FIXED_PRODUCT_ACC_SATURATE_EN
        chk("narrow_1016", dout_n, 127);
`else
        chk("narrow_1016", dout_n, 32'hF8);
`endif
        cycle(0, zero_beat, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 80; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  mk($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, zero_beat, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixed_product_vector_accumulator.md
FIXED_PRODUCT_VECTOR_ACCUMULATOR -- requirements
Module: fixed_product_vector_accumulator

Interface
REQ-001 SHALL have parameter IN_SIZE, default 4: elements per input beat (product vector length).
REQ-002 SHALL have parameter IN_WIDTH, default 32: signed two's-complement width of each product element.
REQ-003 SHALL have parameter IN_DEPTH, default 4: beats accumulated per dot product, at least 1.
REQ-004 SHALL have parameter ACC_WIDTH, default IN_WIDTH+$clog2(IN_SIZE)+$clog2(IN_DEPTH): internal full-precision width.
REQ-005 SHALL have parameter OUT_WIDTH, default ACC_WIDTH: result width, at most ACC_WIDTH.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (low = reset asserted).
REQ-008 SHALL have port data_in, input, array [IN_SIZE-1:0] of IN_WIDTH bits: product vector beat.
REQ-009 SHALL have port data_in_valid (input, 1) and data_in_ready (output, 1): input valid/ready handshake.
REQ-010 SHALL have port data_out, output, OUT_WIDTH bits: completed dot product, signed.
REQ-011 SHALL have port data_out_valid (output, 1) and data_out_ready (input, 1): output valid/ready handshake.

Function
REQ-012 SHALL accept a beat only when data_in_valid and data_in_ready are both high on a rising clk edge.
REQ-013 SHALL sign-extend every element to ACC_WIDTH and reduce the IN_SIZE elements to one beat sum combinationally, without overflow.
REQ-014 SHALL hold a beat counter cnt (0..IN_DEPTH-1) and an accumulator acc (ACC_WIDTH bits).
REQ-015 SHALL, on an accepted beat with cnt<IN_DEPTH-1 (state ACCUM), set acc<=acc+beat_sum and cnt<=cnt+1.
REQ-016 SHALL, on an accepted beat with cnt==IN_DEPTH-1 (final beat), load the output register with the narrowed value of acc+beat_sum, set data_out_valid<=1, clear acc to 0 and wrap cnt to 0.
REQ-017 SHALL, when IN_DEPTH==1, treat every accepted beat as a final beat.
REQ-018 SHALL assert data_out_valid exactly one cycle after the final beat is accepted. Full throughput is one beat per cycle.
REQ-019 SHALL drive data_in_ready = !data_out_valid || data_out_ready. All beats stall while the output register is full and not being drained.
REQ-020 SHALL hold data_out stable while data_out_valid is high and data_out_ready is low.
REQ-021 SHALL clear data_out_valid on an output handshake unless a final beat is accepted in the same cycle, in which case the new result loads and valid stays high.
REQ-022 SHALL keep acc and cnt unchanged on cycles with no accepted beat.
REQ-023 SHALL not depend combinationally on data_out_ready for data_out or data_out_valid.

Reset
REQ-024 SHALL, on rst low, immediately clear cnt to 0, acc to 0, data_out to 0 and data_out_valid to 0, regardless of clk.
REQ-025 SHALL discard any partial accumulation on reset mid-operation; the first beat after release starts a new dot product.
REQ-026 SHALL drive data_in_ready high during and after reset, since the output register is empty.

Configuration
REQ-027 SHALL use macro FIXED_PRODUCT_ACC_SATURATE_EN to select narrowing from ACC_WIDTH to OUT_WIDTH.
REQ-028 With FIXED_PRODUCT_ACC_SATURATE_EN defined, the narrowed value SHALL clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-029 Without FIXED_PRODUCT_ACC_SATURATE_EN, the narrowed value SHALL be the low OUT_WIDTH bits (wrap).
REQ-030 When OUT_WIDTH==ACC_WIDTH, both macro settings SHALL give identical results.

Verification (IN_SIZE=4, IN_DEPTH=2, IN_WIDTH=8, default widths unless stated)
REQ-031 SHALL cover: beats {1,2,3,4},{5,6,7,8}, ready high -> data_out=36, valid one cycle after second beat.
REQ-032 SHALL cover: beats {-1,-1,-1,-1} twice -> data_out=-8 (0x7F8, 11 bits).
REQ-033 SHALL cover: result pending with data_out_ready low 3 cycles, next vector presented -> data_in_ready low those 3 cycles, data_out held, next result correct after drain.
REQ-034 SHALL cover: back-to-back vectors with ready high -> one result every 2 cycles, no bubbles or drops.
REQ-035 SHALL cover: one beat {9,9,9,9}, rst pulsed low mid-cycle, then {1,1,1,1},{1,1,1,1} -> valid cleared asynchronously, next data_out=8.
REQ-036 SHALL cover: OUT_WIDTH=8, beats of all 127 twice (sum 1016) -> 127 with FIXED_PRODUCT_ACC_SATURATE_EN; -8 (0xF8) without.
